// File: rtl/sa_pkg.sv
// Shared switch-allocator parameters, used by both the input-port and output-port stages.
package sa_pkg;
    localparam int N            = 5;
    localparam int V            = 4;
    localparam int VW           = $clog2(V);
    localparam int CREDIT_DEPTH = 4;
    localparam int CW           = $clog2(CREDIT_DEPTH + 1);
endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner only on a grant.
module sa_rr_arbiter
    import sa_pkg::*;
#(
    parameter int NR = sa_pkg::N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NR-1:0] req_i,
    output logic [NR-1:0] grant_o
);
    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        for (int off = 0; off < NR; off++) begin
            idx = PW'((int'(ptr_q) + off) % NR);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win          = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win == PW'(NR - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/sa_oport.sv
// Switch-allocator output-port stage: credit tracking, eligibility filter, RR pick, crossbar select register.
// Optional SA_OPORT_CREDIT_BYPASS_EN lets a credit returned this cycle be consumed in the same cycle.
module sa_oport
    import sa_pkg::*;
#(
    parameter int N            = sa_pkg::N,
    parameter int V            = sa_pkg::V,
    parameter int CREDIT_DEPTH = sa_pkg::CREDIT_DEPTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [N-1:0]                     req_in,
    input  logic [N*((V>1)?$clog2(V):1)-1:0] req_vc_in,
    input  logic [V-1:0]                     credit_in,
    output logic [N-1:0]                     grant_out,
    output logic [V-1:0]                     credit_avail_out,
    output logic                             xbar_valid_out,
    output logic [N-1:0]                     xbar_sel_out,
    output logic [((V>1)?$clog2(V):1)-1:0]   xbar_vc_out,
    output logic                             err_out
);
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    logic [CW-1:0] cnt_q [V];
    logic [CW-1:0] cnt_d [V];
    logic          err_q, err_d;
    logic [V-1:0]  avail;
    logic [V-1:0]  consume;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant_raw;
    logic [VW-1:0] win_vc;
    logic          xbar_valid_q;
    logic [N-1:0]  xbar_sel_q;
    logic [VW-1:0] xbar_vc_q;

    always_comb begin
        avail = '0;
        for (int v = 0; v < V; v++) begin
`ifdef SA_OPORT_CREDIT_BYPASS_EN
            avail[v] = (cnt_q[v] != '0) | credit_in[v];
`else
            avail[v] = (cnt_q[v] != '0);
`endif
        end
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = req_in[i] & avail[req_vc_in[i*VW +: VW]];
        end
    end

    sa_rr_arbiter #(.NR(N)) u_arb (
        .clk     (clk),
        .rst     (rstn),
        .req_i   (eligible),
        .grant_o (grant_raw)
    );

    always_comb begin
        win_vc = '0;
        for (int i = 0; i < N; i++) begin
            win_vc = win_vc | (grant_raw[i] ? req_vc_in[i*VW +: VW] : '0);
        end
        consume = '0;
        for (int v = 0; v < V; v++) begin
            consume[v] = (|grant_raw) && (win_vc == VW'(v));
        end
        // Return without consume at full depth saturates and flags an overflow.
        err_d = err_q;
        for (int v = 0; v < V; v++) begin
            cnt_d[v] = cnt_q[v];
            if (credit_in[v] && !consume[v]) begin
                if (cnt_q[v] == CW'(CREDIT_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end else if (consume[v] && !credit_in[v]) begin
                cnt_d[v] = cnt_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int v = 0; v < V; v++) begin
                cnt_q[v] <= CW'(CREDIT_DEPTH);
            end
            err_q        <= 1'b0;
            xbar_valid_q <= 1'b0;
            xbar_sel_q   <= '0;
            xbar_vc_q    <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
            err_q        <= err_d;
            xbar_valid_q <= |grant_raw;
            xbar_sel_q   <= grant_raw;
            xbar_vc_q    <= (|grant_raw) ? win_vc : '0;
        end
    end

    always_comb begin
        credit_avail_out = '0;
        for (int v = 0; v < V; v++) begin
            credit_avail_out[v] = (cnt_q[v] != '0);
        end
    end

    assign grant_out      = rstn ? '0 : grant_raw;
    assign xbar_valid_out = xbar_valid_q;
    assign xbar_sel_out   = xbar_sel_q;
    assign xbar_vc_out    = xbar_vc_q;
    assign err_out        = err_q;
endmodule

// File: tb/tb_sa_oport.sv
// Self-checking bench for sa_oport; expected grants are queued per scenario and popped as cycles run.
// Build with SA_OPORT_CREDIT_BYPASS_EN defined to check the same-cycle credit bypass variant.
module tb_sa_oport;
    localparam int N  = 5;
    localparam int V  = 4;
    localparam int VW = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_in;
    logic [N*VW-1:0] req_vc_in;
    logic [V-1:0]    credit_in;
    logic [N-1:0]    grant_out;
    logic [V-1:0]    credit_avail_out;
    logic            xbar_valid_out;
    logic [N-1:0]    xbar_sel_out;
    logic [VW-1:0]   xbar_vc_out;
    logic            err_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_g;

    sa_oport dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_in           (req_in),
        .req_vc_in        (req_vc_in),
        .credit_in        (credit_in),
        .grant_out        (grant_out),
        .credit_avail_out (credit_avail_out),
        .xbar_valid_out   (xbar_valid_out),
        .xbar_sel_out     (xbar_sel_out),
        .xbar_vc_out      (xbar_vc_out),
        .err_out          (err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N*VW-1:0] vc_all(input int v);
        logic [N*VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*VW +: VW] = VW'(v);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b1;
        req_in    = '0;
        req_vc_in = '0;
        credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b1;
        req_in    = 5'b11111;
        req_vc_in = '0;
        credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (grant_out !== 5'b00000) $display("FAIL reset_grant: got %b want 00000", grant_out);
        else pass_cnt++;
        chk_cnt++;
        if (credit_avail_out !== 4'b1111) $display("FAIL reset_avail: got %b want 1111", credit_avail_out);
        else pass_cnt++;
        chk_cnt++;
        if ({xbar_valid_out, xbar_sel_out, xbar_vc_out, err_out} !== 9'b0)
            $display("FAIL reset_regs: got v=%b sel=%b vc=%0d err=%b want all 0",
                     xbar_valid_out, xbar_sel_out, xbar_vc_out, err_out);
        else pass_cnt++;
        req_in = '0;
        rstn   = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req_in    = 5'b00110;
        req_vc_in = vc_all(0);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100);
        #1;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL basic_g0: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (xbar_sel_out !== 5'b00010 || xbar_valid_out !== 1'b1 || xbar_vc_out !== 2'd0)
            $display("FAIL basic_xbar: got v=%b sel=%b vc=%0d want 1 00010 0",
                     xbar_valid_out, xbar_sel_out, xbar_vc_out);
        else pass_cnt++;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL basic_g1: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
        step();
        req_in = '0;
        #1;
        chk_cnt++;
        if (grant_out !== 5'b00000) $display("FAIL basic_idle: got %b want 00000", grant_out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (xbar_valid_out !== 1'b0 || xbar_sel_out !== 5'b0)
            $display("FAIL basic_xbar_idle: got v=%b sel=%b want 0 00000", xbar_valid_out, xbar_sel_out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_in    = 5'b11111;
        req_vc_in = vc_all(2);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_g = exp_q.pop_front();
            chk_cnt++;
            if (grant_out !== exp_g) $display("FAIL b2b_grant[%0d]: got %b want %b", c, grant_out, exp_g);
            else pass_cnt++;
            step();
            if (c == 0) begin
                chk_cnt++;
                if (xbar_vc_out !== 2'd2) $display("FAIL b2b_xbar_vc: got %0d want 2", xbar_vc_out);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (credit_avail_out !== 4'b1011) $display("FAIL b2b_avail: got %b want 1011", credit_avail_out);
        else pass_cnt++;
        req_in = '0;
    endtask

    task automatic test_credit_bypass();
        do_reset();
        req_in    = 5'b01000;
        req_vc_in = vc_all(1);
        repeat (4) step();
        chk_cnt++;
        if (credit_avail_out !== 4'b1101) $display("FAIL byp_drained: got %b want 1101", credit_avail_out);
        else pass_cnt++;
        credit_in = 4'b0010;
`ifdef SA_OPORT_CREDIT_BYPASS_EN
        exp_q.push_back(5'b01000);
`else
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b01000);
`endif
        #1;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL byp_return_cycle: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
        step();
        credit_in = '0;
        #1;
`ifdef SA_OPORT_CREDIT_BYPASS_EN
        chk_cnt++;
        if (credit_avail_out !== 4'b1101) $display("FAIL byp_avail: got %b want 1101", credit_avail_out);
        else pass_cnt++;
`else
        chk_cnt++;
        if (credit_avail_out !== 4'b1111) $display("FAIL byp_avail: got %b want 1111", credit_avail_out);
        else pass_cnt++;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL byp_next_cycle: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
`endif
        step();
        req_in = '0;
    endtask

    task automatic test_simul_credit();
        do_reset();
        req_in    = 5'b00001;
        req_vc_in = vc_all(0);
        for (int c = 0; c < 5; c++) exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
        for (int c = 0; c < 6; c++) begin
            credit_in = (c == 2) ? 4'b0001 : 4'b0000;
            #1;
            exp_g = exp_q.pop_front();
            chk_cnt++;
            if (grant_out !== exp_g) $display("FAIL simul_grant[%0d]: got %b want %b", c, grant_out, exp_g);
            else pass_cnt++;
            step();
        end
        credit_in = '0;
        req_in    = '0;
        chk_cnt++;
        if (credit_avail_out !== 4'b1110) $display("FAIL simul_avail: got %b want 1110", credit_avail_out);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        credit_in = 4'b1000;
        step();
        credit_in = '0;
        chk_cnt++;
        if (err_out !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", err_out);
        else pass_cnt++;
        repeat (3) step();
        chk_cnt++;
        if (err_out !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", err_out);
        else pass_cnt++;
        req_in    = 5'b00001;
        req_vc_in = vc_all(3);
        for (int c = 0; c < 4; c++) exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_g = exp_q.pop_front();
            chk_cnt++;
            if (grant_out !== exp_g) $display("FAIL ovf_drain[%0d]: got %b want %b", c, grant_out, exp_g);
            else pass_cnt++;
            step();
        end
        req_in = '0;
        chk_cnt++;
        if (credit_avail_out !== 4'b0111 || err_out !== 1'b1)
            $display("FAIL ovf_final: got avail=%b err=%b want 0111 1", credit_avail_out, err_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_in    = 5'b11111;
        req_vc_in = vc_all(0);
        repeat (3) step();
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00001);
        #1;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL mid_pre: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
        rstn = 1'b1;
        #1;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g || xbar_valid_out !== 1'b0 || credit_avail_out !== 4'b1111)
            $display("FAIL mid_async: got g=%b v=%b avail=%b want %b 0 1111",
                     grant_out, xbar_valid_out, credit_avail_out, exp_g);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        exp_g = exp_q.pop_front();
        chk_cnt++;
        if (grant_out !== exp_g) $display("FAIL mid_release: got %b want %b", grant_out, exp_g);
        else pass_cnt++;
        step();
        req_in = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_credit_bypass();
        test_simul_credit();
        test_overflow();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/sa_oport.md
# sa_oport

Output-port stage of the switch allocator: the far end of the per-input-port request path. Collects one request per input port for this output port, filters requests whose target downstream VC has no credit, picks one winner with a round-robin arbiter, and returns a one-hot grant to the input ports in the same cycle. Tracks downstream buffer credits per VC and registers the crossbar select for the following switch-traversal stage.

## Interface
- N, 5 (`N`): number of router ports (requesters)
- V, 4 (`V`): VCs per port
- VW, $clog2(V): VC index width
- CREDIT_DEPTH, 4: downstream buffer slots per VC
- CW, $clog2(CREDIT_DEPTH+1): credit counter width
- clk  input  1  sole clock, rising edge
- rstn  input  1  reset; asynchronous, active-high (1 = reset)
- req_in  input  N  bit i: input port i requests this output
- req_vc_in  input  N*VW  slice i: downstream VC targeted by input port i
- credit_in  input  V  bit v: one credit returned for downstream VC v (1-cycle pulse)
- grant_out  output  N  one-hot/zero grant to input ports, combinational
- credit_avail_out  output  V  bit v = credit counter v nonzero (registered state)
- xbar_valid_out  output  1  registered: a flit traverses next cycle
- xbar_sel_out  output  N  registered one-hot copy of grant
- xbar_vc_out  output  VW  registered VC index of the granted flit
- err_out  output  1  sticky credit-overflow flag

## Operation
- eligible[i] = req_in[i] & avail[req_vc_in slice i]; avail per Configuration.
- Round-robin: index pointer ptr (0..N-1); winner = first eligible index scanning ptr, ptr+1, …, wrapping N-1 -> 0.
- grant_out = one-hot of winner; all-zero if nothing eligible; at most one bit ever set.
- On grant to port w: ptr <= (w+1) mod N. No grant: ptr holds.
- Credit counter v next = cnt[v] - consume[v] + credit_in[v]; consume[v] = grant issued with winner VC == v.
- Simultaneous consume and return on same VC: counter unchanged.
- Return at cnt == CREDIT_DEPTH without consume: counter saturates, err_out <= 1 (sticky until reset).
- Consume never occurs at cnt == 0 (guaranteed by eligibility); no underflow path.
- req_in bits with no eligible credit are ignored, not queued; requester retries.

## Timing
- Grant: 0 cycles (combinational from req_in, req_vc_in, state).
- xbar_*: 1 cycle after grant edge; xbar_valid_out = 1 exactly in cycles following a grant.
- Counters, ptr, err_out update on rising clk.
- Reset (async assert, any time, incl. mid-stream): ptr=0, cnt[v]=CREDIT_DEPTH, err_out=0, xbar_valid_out=0, xbar_sel_out=0, xbar_vc_out=0, grant_out=0 while rstn=1, credit_avail_out=all ones after reset.
- Back-to-back grants each cycle are allowed (no bubble).

## Configuration
- SA_OPORT_CREDIT_BYPASS_EN defined: avail[v] = (cnt[v] != 0) | credit_in[v]; a credit returned this cycle can be consumed this cycle.
- Undefined: avail[v] = (cnt[v] != 0); a returned credit is usable from the next cycle. credit_avail_out always reflects the counter only.

## Structure
- Shared package sa_pkg: N, V, VW, CREDIT_DEPTH, CW defaults; used with sa_iport.
- Sub-module sa_rr_arbiter (N requests, pointer state, advance-on-grant only, hold otherwise); sa_oport holds credit counters, eligibility, and xbar registers.

## Test plan
- Reset then req_in=5'b00110, VCs 0 -> grant_out=5'b00010; next cycle same -> 5'b00100; xbar_sel_out=5'b00010 one cycle after first grant.
- All 5 ports request VC2 continuously, no credits returned -> grants ports 0,1,2,3 then nothing; cnt[2]=0, credit_avail_out=4'b1011.
- With cnt[1]=0, credit_in[1] pulse and port 3 requesting VC1: grant same cycle with SA_OPORT_CREDIT_BYPASS_EN, one cycle later without.
- Grant on VC0 plus credit_in[0] same cycle at cnt[0]=2 -> cnt[0] stays 2.
- credit_in[3] at cnt[3]=4, no consume -> cnt[3]=4, err_out=1 and stays 1.
- Assert rstn mid-stream after ptr=3 -> grant_out=0 immediately; after release with req_in=5'b11111, grant_out=5'b00001.
